// File: rtl/riscv_pkg.sv
// Shared RV32I core constants: datapath width, reset vector, sequential step, PC source encoding.
package riscv_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam int          PC_INC       = 4;

    localparam logic PCSRC_SEQ    = 1'b0;
    localparam logic PCSRC_BRANCH = 1'b1;

endpackage

// File: rtl/pc_adder.sv
// Unsigned WIDTH-bit adder, modulo 2^WIDTH; carry-out is dropped.
// Purely combinational, zero latency, no flow control.
module pc_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/next_pc_logic.sv
// Next-PC select (PC+4 or PC+ImmExt) with misalignment flag; combinational NextPC, pc_q one edge later.
// No backpressure: pc_en=0 stalls pc_q, synchronous active-low reset wins over pc_en.
module next_pc_logic #(
    parameter int               XLEN         = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_VECTOR = riscv_pkg::RESET_VECTOR,
    parameter int               PC_INC       = riscv_pkg::PC_INC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_en,
    input  logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] ImmExt,
    input  logic            PCSrc,
    output logic [XLEN-1:0] NextPC,
    output logic [XLEN-1:0] pc_q,
    output logic            misaligned
);

    import riscv_pkg::*;

    localparam logic [XLEN-1:0] INC_STEP = XLEN'(PC_INC);

    logic [XLEN-1:0] seqTarget;
    logic [XLEN-1:0] branchTarget;

    pc_adder #(.WIDTH(XLEN)) uSeqAdder (
        .a   (PC),
        .b   (INC_STEP),
        .sum (seqTarget)
    );

    pc_adder #(.WIDTH(XLEN)) uBranchAdder (
        .a   (PC),
        .b   (ImmExt),
        .sum (branchTarget)
    );

    assign NextPC = (PCSrc == PCSRC_BRANCH) ? branchTarget : seqTarget;

    // Informative only: the trap unit decides what to do with a misaligned target.
    assign misaligned = |NextPC[1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_VECTOR;
        end else if (pc_en) begin
            pc_q <= NextPC;
        end
    end

endmodule

// File: tb/tb_next_pc_logic.sv
// Randomized and directed check of next_pc_logic against an arithmetic reference model.
module tb_next_pc_logic;

    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_en;
    logic [31:0] PC;
    logic [31:0] ImmExt;
    logic        PCSrc;
    logic [31:0] NextPC;
    logic [31:0] pc_q;
    logic        misaligned;

    int          vecCnt = 0;
    int          errCnt = 0;
    logic [31:0] expPc;

    always #5 clk = ~clk;

    next_pc_logic dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_en      (pc_en),
        .PC         (PC),
        .ImmExt     (ImmExt),
        .PCSrc      (PCSrc),
        .NextPC     (NextPC),
        .pc_q       (pc_q),
        .misaligned (misaligned)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Target = PC plus offset-or-4 done in 64-bit arithmetic, then reduced modulo 2^32.
    function automatic logic [31:0] refNext(input logic [31:0] pc, input logic [31:0] imm,
                                            input logic src);
        longint unsigned s;
        s = longint'(pc) + (src ? longint'(imm) : 64'd4);
        return 32'(s % 64'h1_0000_0000);
    endfunction

    function automatic logic [31:0] refMis(input logic [31:0] pc, input logic [31:0] imm,
                                           input logic src);
        return (refNext(pc, imm, src) % 4 != 0) ? 32'd1 : 32'd0;
    endfunction

    task automatic checkComb(input string tag);
        #1;
        chk({tag, ".next"}, NextPC, refNext(PC, ImmExt, PCSrc));
        chk({tag, ".mis"}, {31'b0, misaligned}, refMis(PC, ImmExt, PCSrc));
    endtask

    task automatic directed(input string tag, input logic [31:0] pc, input logic [31:0] imm,
                            input logic src, input logic [31:0] expNext, input logic expMis);
        PC     = pc;
        ImmExt = imm;
        PCSrc  = src;
        #1;
        chk({tag, ".next"}, NextPC, expNext);
        chk({tag, ".mis"}, {31'b0, misaligned}, {31'b0, expMis});
    endtask

    task automatic clockStep(input string tag);
        @(posedge clk);
        if (!rst_n)
            expPc = RESET_VECTOR;
        else if (pc_en)
            expPc = refNext(PC, ImmExt, PCSrc);
        #1;
        chk({tag, ".pc_q"}, pc_q, expPc);
    endtask

    initial begin
        rst_n  = 1'b0;
        pc_en  = 1'b1;
        PC     = 32'h0;
        ImmExt = 32'h0;
        PCSrc  = PCSRC_SEQ;
        expPc  = 32'hxxxx_xxxx;

        // Combinational path keeps working while reset is held.
        directed("seq",      32'h0000_1000, 32'h0000_0040, 1'b0, 32'h0000_1004, 1'b0);
        directed("fwd",      32'h0000_1000, 32'h0000_0040, 1'b1, 32'h0000_1040, 1'b0);
        directed("bwd_wrap", 32'h0000_0010, 32'hFFFF_FFF0, 1'b1, 32'h0000_0000, 1'b0);
        directed("seq_wrap", 32'hFFFF_FFFC, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0);
        directed("misalign", 32'h0000_2000, 32'h0000_0006, 1'b1, 32'h0000_2006, 1'b1);
        directed("bwd",      32'h0000_3000, 32'hFFFF_FF00, 1'b1, 32'h0000_2F00, 1'b0);

        for (int i = 0; i < 16; i++) begin
            PC     = $urandom;
            ImmExt = $urandom;
            PCSrc  = i[0];
            checkComb("rand_comb");
        end

        // Register path with literal expectations.
        PC    = 32'h0000_0100;
        PCSrc = PCSRC_SEQ;
        clockStep("rst1");
        clockStep("rst2");
        chk("rst_val", pc_q, 32'h0000_0000);

        rst_n = 1'b1;
        clockStep("load");
        chk("load_val", pc_q, 32'h0000_0104);

        pc_en = 1'b0;
        PC    = 32'h0000_0200;
        clockStep("hold");
        chk("hold_val", pc_q, 32'h0000_0104);

        pc_en = 1'b1;
        rst_n = 1'b0;
        PCSrc = PCSRC_BRANCH;
        ImmExt = 32'h0000_0080;
        clockStep("rst_mid");
        chk("rst_mid_val", pc_q, 32'h0000_0000);
        rst_n = 1'b1;

        // Mixed random operation: stalls, branches and occasional resets.
        for (int i = 0; i < 60; i++) begin
            PC     = $urandom;
            ImmExt = $urandom;
            PCSrc  = 1'($urandom_range(0, 1));
            pc_en  = ($urandom_range(0, 3) != 0);
            rst_n  = ($urandom_range(0, 15) != 0);
            checkComb("rand_seq");
            clockStep("rand_seq");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
